// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - access-size encodings carried on req_size
//   - FSM state type used by load_store_unit
//   - is_misaligned(): alignment rule for an access of a given size
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  // Bytes are always aligned, halves need addr[0] = 0, words need
  // addr[1:0] = 0. The reserved size code is treated as misaligned so the
  // datapath traps instead of touching memory.
  function automatic logic is_misaligned(input logic [1:0] sz,
                                         input logic [1:0] lo);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for a 32-bit little-endian word.
//   size     : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   lane     : byte address bits [1:0]
//   sign_ext : 1 = sign-extend a sub-word load, 0 = zero-extend
//   rdata    : word to extract a load from
//   base     : old memory word for a sub-word store
//   wdata    : right-justified store data
//   load_ext : extracted and extended load value
//   merged   : base with the addressed lane replaced (wdata for a word)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] base,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    load_ext = rdata;
    case (size)
      SZ_BYTE: load_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_ext = rdata;
    endcase

    merged = wdata;
    case (size)
      SZ_BYTE: begin
        merged = base;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        merged = base;
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the single-cycle datapath and a word-organised
// data memory with asynchronous read. Sub-word stores use read-modify-write,
// sub-word loads are extracted and extended; misaligned requests are
// flagged combinationally and never reach memory.
//
// Handshake: req_valid marks a memory instruction. While stall = 1 the
// datapath holds req_* stable; the cycle stall drops (WRITE, RESP, or a
// misaligned request) is the cycle the datapath advances. A request seen
// in WRITE or RESP is ignored; only IDLE accepts.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req_valid/write/size/signed/addr/wdata   request from the datapath
//   stall, misaligned  combinational hold / address exception
//   load_valid         one-cycle pulse with load_data (registered)
//   mem_addr/read/write/wdata, mem_rdata     word memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int size   = 32,
  parameter int length = 256,
  localparam int AW    = $clog2(length)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW+1:0]   req_addr,
  input  logic [size-1:0] req_wdata,
  output logic            stall,
  output logic            misaligned,
  output logic            load_valid,
  output logic [size-1:0] load_data,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_read,
  output logic            mem_write,
  output logic [size-1:0] mem_wdata,
  input  logic [size-1:0] mem_rdata
);

  lsu_state_e state, state_nx;

  // Request registers and read buffer.
  logic            write_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [AW+1:0]   addr_q;
  logic [size-1:0] wdata_q;
  logic [size-1:0] rbuf;

  logic            bad_align;
  logic            accept;
  logic [size-1:0] load_ext;
  logic [size-1:0] merged;

  assign bad_align = is_misaligned(req_size, req_addr[1:0]);
  assign accept    = (state == ST_IDLE) && req_valid && !bad_align;

  assign misaligned = (state == ST_IDLE) && req_valid && bad_align;
  assign stall      = accept || (state == ST_READ);

  // mem_addr comes only from the captured address, so it holds its last
  // value through IDLE.
  assign mem_addr  = addr_q[AW+1:2];
  assign mem_wdata = merged;

  // Extraction works on mem_rdata during READ so load_data can be
  // registered at the READ->RESP edge and be valid with load_valid.
  lsu_lane_align u_align (
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .sign_ext (signed_q),
    .rdata    (mem_rdata),
    .base     (rbuf),
    .wdata    (wdata_q),
    .load_ext (load_ext),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    load_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          // Only a full-word store can skip the read.
          if (req_write && (req_size == SZ_WORD)) state_nx = ST_WRITE;
          else                                     state_nx = ST_READ;
        end
      end
      ST_READ: begin
        mem_read = 1'b1;
        state_nx = write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_write = 1'b1;
        state_nx  = ST_IDLE;
      end
      ST_RESP: begin
        load_valid = 1'b1;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q   <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf      <= '0;
      load_data <= '0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state == ST_READ) begin
        rbuf <= mem_rdata;
        if (!write_q) load_data <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int AW = 8;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          stall, misaligned, load_valid, mem_read, mem_write;
  logic [31:0]   load_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  load_store_unit #(.size(32), .length(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .misaligned(misaligned),
    .load_valid(load_valid), .load_data(load_data),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word memory with asynchronous read.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  // Reference memory image, updated when a store is issued.
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_q[$];
  logic [39:0] exp_wq[$];
  int n_tests = 0, n_fail = 0, n_lv = 0, n_loads = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = (lo >= 2) ? w[31:16] : w[15:0];
    if (sz == B) return sg ? {{24{b[7]}}, b} : {24'h0, b};
    if (sz == H) return sg ? {{16{h[15]}}, h} : {16'h0, h};
    return w;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lo, input logic [31:0] d);
    if (sz == B) begin
      case (lo)
        2'd0: return {w[31:8], d[7:0]};
        2'd1: return {w[31:16], d[7:0], w[7:0]};
        2'd2: return {w[31:24], d[7:0], w[15:0]};
        default: return {d[7:0], w[23:0]};
      endcase
    end
    if (sz == H) return (lo >= 2) ? {d[15:0], w[15:0]} : {w[31:16], d[15:0]};
    return d;
  endfunction

  // Scoreboard: compare whatever the DUT produces with the expected queues.
  always @(negedge clk) begin
    if (load_valid) begin
      n_lv++;
      check("lv_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("load_data", 64'(load_data), 64'(exp_q.pop_front()));
    end
    if (mem_write) begin
      check("wr_pending", 64'(exp_wq.size() != 0), 64'd1);
      if (exp_wq.size() != 0) check("mem_wr", 64'({mem_addr, mem_wdata}), 64'(exp_wq.pop_front()));
    end
  end

  // Drive one request (called at posedge+1), hold it until stall drops,
  // check strobe timing, then release it at the following edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [AW+1:0] addr, input logic [31:0] wd);
    logic       mis, st;
    logic [1:0] lo;
    logic [7:0] wa;
    logic [7:0] rd_m, wr_m, lv_m, e_rd, e_wr, e_lv;
    int         cyc, e_len;
    logic [31:0] nw;
    lo  = addr[1:0];
    wa  = addr[AW+1:2];
    mis = (sz == X) || (sz == H && lo[0]) || (sz == W && lo != 2'd0);
    e_rd = 8'h0; e_wr = 8'h0; e_lv = 8'h0; e_len = 0;
    if (!mis) begin
      if (wr) begin
        nw = ref_store(ref_mem[wa], sz, lo, wd);
        exp_wq.push_back({wa, nw});
        ref_mem[wa] = nw;
        if (sz == W) begin e_wr = 8'b0000_0010; e_len = 1; end
        else begin e_rd = 8'b0000_0010; e_wr = 8'b0000_0100; e_len = 2; end
      end else begin
        exp_q.push_back(ref_load(ref_mem[wa], sz, sg, lo));
        n_loads++;
        e_rd = 8'b0000_0010; e_lv = 8'b0000_0100; e_len = 2;
      end
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    cyc = 0; rd_m = 0; wr_m = 0; lv_m = 0;
    do begin
      @(negedge clk);
      if (cyc == 0) check("misaligned", 64'(misaligned), 64'(mis));
      if (mem_read) check("rd_addr", 64'(mem_addr), 64'(wa));
      rd_m[cyc] = mem_read; wr_m[cyc] = mem_write; lv_m[cyc] = load_valid;
      st = stall;
      cyc++;
    end while (st && cyc < 8);
    check("stall_len", 64'(cyc - 1), 64'(e_len));
    check("rd_timing", 64'(rd_m), 64'(e_rd));
    check("wr_timing", 64'(wr_m), 64'(e_wr));
    check("lv_timing", 64'(lv_m), 64'(e_lv));
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (mis) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("mis_quiet", 64'({mem_read, mem_write}), 64'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_stall"}, 64'(stall), 64'd0);
    check({tag, "_mis"}, 64'(misaligned), 64'd0);
    check({tag, "_strobes"}, 64'({mem_read, mem_write, load_valid}), 64'd0);
    check({tag, "_load_data"}, 64'(load_data), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Assert reset while the request sits in READ and hold it two edges.
  task automatic reset_in_read(input logic wr, input logic [1:0] sz, input logic [AW+1:0] addr);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = 1'b1;
    req_addr = addr; req_wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_quiet", 64'({mem_write, load_valid}), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;

    issue(1'b1, W, 1'b0, 10'h010, 32'hDEADBEEF);
    issue(1'b1, W, 1'b0, 10'h010, 32'h11223344);
    issue(1'b1, B, 1'b0, 10'h013, 32'h000000AA);   // word 4 -> 0xAA223344
    issue(1'b1, W, 1'b0, 10'h010, 32'h11F23344);
    issue(1'b0, B, 1'b1, 10'h012, 32'h0);          // 0xFFFFFFF2
    issue(1'b0, H, 1'b0, 10'h012, 32'h0);          // 0x000011F2
    issue(1'b0, W, 1'b0, 10'h011, 32'h0);          // misaligned word
    issue(1'b0, H, 1'b1, 10'h013, 32'h0);          // misaligned half
    issue(1'b1, X, 1'b0, 10'h010, 32'h12345678);   // illegal size
    issue(1'b0, W, 1'b0, 10'h010, 32'h0);          // back-to-back loads
    issue(1'b0, H, 1'b1, 10'h010, 32'h0);
    issue(1'b1, H, 1'b0, 10'h016, 32'hCAFE8001);
    issue(1'b0, H, 1'b1, 10'h016, 32'h0);

    reset_in_read(1'b0, W, 10'h010);
    reset_in_read(1'b1, B, 10'h011);
    issue(1'b0, W, 1'b0, 10'h010, 32'h0);          // accepted after reset

    for (int i = 0; i < 8; i++)
      issue(1'b1, W, 1'b0, 10'(i * 4), $urandom());
    for (int i = 0; i < 60; i++)
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            10'($urandom_range(0, 31)), $urandom());

    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("exp_wq_empty", 64'(exp_wq.size()), 64'd0);
    check("lv_count", 64'(n_lv), 64'(n_loads));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
